// File: rtl/rca_arbiter.sv
// rtl/rca_arbiter.sv - round-robin arbiter sharing one ripple-carry adder between two requesters
// Optional grant counters are built when RCA_ARBITER_STATS_EN is defined.

module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   sum
);
  logic [SIZE:0]   carry;
  logic [SIZE-1:0] s;

  // No carry-in: overflow shows up only in the MSB of the result.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  assign sum = {carry[SIZE], s};
endmodule

module rca_arbiter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE:0]   rsp_result
`ifdef RCA_ARBITER_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [15:0]     grant_cnt0,
  output logic [15:0]     grant_cnt1
`endif
);
  // EMPTY/FULL is carried directly by rsp_valid_q.
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [SIZE:0]   rsp_result_q, rsp_result_d;
  logic            rr_ptr_q, rr_ptr_d;

  logic            can_accept;
  logic            grant_any;
  logic            grant_idx;
  logic            accept;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic [SIZE:0]   sum;

  always_comb begin
    can_accept = (rsp_valid_q == ST_EMPTY) | rsp_ready;
    grant_any  = req0_valid | req1_valid;
    // Contention defers to the pointer; a lone requester always wins.
    if (req0_valid & req1_valid) begin
      grant_idx = rr_ptr_q;
    end else begin
      grant_idx = req1_valid;
    end
    req0_ready = ~rst & can_accept & grant_any & ~grant_idx & req0_valid;
    req1_ready = ~rst & can_accept & grant_any &  grant_idx & req1_valid;
    accept     = req0_ready | req1_ready;
    op_a       = grant_idx ? req1_a : req0_a;
    op_b       = grant_idx ? req1_b : req0_b;
  end

  rca_adder #(.SIZE(SIZE)) u_rca (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      rsp_valid_d  = ST_FULL;
      rsp_id_d     = grant_idx;
      rsp_result_d = sum;
      rr_ptr_d     = ~grant_idx;
    end else if (rsp_ready) begin
      rsp_valid_d  = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= ST_EMPTY;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rr_ptr_q     <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

`ifdef RCA_ARBITER_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  // Clear wins over increment; counts stick at all-ones.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (stats_clr) begin
      grant_cnt0_d = '0;
      grant_cnt1_d = '0;
    end else begin
      if (req0_ready && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
      if (req1_ready && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif
endmodule

// File: tb/tb_rca_arbiter.sv
// tb/tb_rca_arbiter.sv - directed bench for rca_arbiter with a per-cycle reference model
module tb_rca_arbiter;
  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0;
  logic            req0_ready;
  logic [SIZE-1:0] req0_a = '0;
  logic [SIZE-1:0] req0_b = '0;
  logic            req1_valid = 1'b0;
  logic            req1_ready;
  logic [SIZE-1:0] req1_a = '0;
  logic [SIZE-1:0] req1_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic            rsp_id;
  logic [SIZE:0]   rsp_result;
`ifdef RCA_ARBITER_STATS_EN
  logic            stats_clr = 1'b0;
  logic [15:0]     grant_cnt0;
  logic [15:0]     grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_arbiter #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef RCA_ARBITER_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one response slot plus a "who goes next on contention" bit.
  logic          m_full = 1'b0;
  logic          m_id = 1'b0;
  logic [SIZE:0] m_result = '0;
  logic          m_next = 1'b0;

  // Returns -1 for no acceptance, else the requester index accepted this cycle.
  function automatic int model_winner();
    if (rst) return -1;
    if (m_full && !rsp_ready) return -1;
    if (req0_valid && req1_valid) return m_next ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = model_winner();
    if (rst) begin
      m_full = 1'b0; m_id = 1'b0; m_result = '0; m_next = 1'b0;
    end else if (w == 0) begin
      m_full = 1'b1; m_id = 1'b0; m_result = {1'b0, req0_a} + {1'b0, req0_b}; m_next = 1'b1;
    end else if (w == 1) begin
      m_full = 1'b1; m_id = 1'b1; m_result = {1'b0, req1_a} + {1'b0, req1_b}; m_next = 1'b0;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
  end

  always @(negedge clk) begin
    int w;
    w = model_winner();
    check("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
    check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    check("rsp_result", {23'd0, rsp_result}, {23'd0, m_result});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            v0;
    logic            v1;
    logic            rr;
    logic [SIZE-1:0] a0;
    logic [SIZE-1:0] b0;
    logic [SIZE-1:0] a1;
    logic [SIZE-1:0] b1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 8'h7F, 8'h01};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 8'h7F, 8'h01};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 8'h7F, 8'h01};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 8'h7F, 8'h01};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'hAA, 8'h55, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'hC3, 8'h3D, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'hFE, 8'h03};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h12, 8'h34};

    // Reset with both requesting: nothing may be accepted.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h01;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", {23'd0, rsp_result}, 32'd0);

    rst = 1'b0;
    #1;
    check("first_grant_req0", {30'd0, req1_ready, req0_ready}, 32'h1);
    tick();
    check("single_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_id", {31'd0, rsp_id}, 32'd0);
    check("single_result", {23'd0, rsp_result}, 32'h010);

    req0_valid = 1'b0;
    #1;
    check("carry_grant_req1", {30'd0, req1_ready, req0_ready}, 32'h2);
    tick();
    check("carry_id", {31'd0, rsp_id}, 32'd1);
    check("carry_result", {23'd0, rsp_result}, 32'h100);

    req1_a = 8'hFF; req1_b = 8'hFF;
    tick();
    check("ffff_result", {23'd0, rsp_result}, 32'h1FE);

    req0_valid = 1'b1; req0_a = 8'd3;  req0_b = 8'd4;
    req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd20;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_result", {23'd0, rsp_result}, (i % 2 == 0) ? 32'h007 : 32'h01E);
      check("rr_valid", {31'd0, rsp_valid}, 32'd1);
    end

    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      check("bp_hold_result", {23'd0, rsp_result}, 32'h01E);
      check("bp_hold_id", {31'd0, rsp_id}, 32'd1);
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_req0", {30'd0, req1_ready, req0_ready}, 32'h1);
    tick();
    check("bp_release_result", {23'd0, rsp_result}, 32'h007);

    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_result", {23'd0, rsp_result}, 32'd0);
    #1;
    check("midrst_grant_req0", {30'd0, req1_ready, req0_ready}, 32'h1);
    tick();
    check("midrst_after_id", {31'd0, rsp_id}, 32'd0);

    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);
    check("drain_hold_result", {23'd0, rsp_result}, 32'h007);

    foreach (vecs[i]) begin
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1; rsp_ready = vecs[i].rr;
      req0_a = vecs[i].a0; req0_b = vecs[i].b0;
      req1_a = vecs[i].a1; req1_b = vecs[i].b1;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
